// File: rtl/card_pkg.sv
// card_pkg: shared card/deck types, constants and shuffler FSM states.
// No ports; imported by deal_shuffler.
package card_pkg;
  typedef logic [1:0] symbol_t;
  localparam symbol_t SYM_NONE = 2'b11;
  localparam int NUM_CARDS = 9;
  localparam int CARDS_PER_SYM = 3;
  typedef logic [2*NUM_CARDS-1:0] deal_t;
  // Ascending packed range puts slot 0 (card1) in the top bits of a deal_t.
  typedef symbol_t [0:NUM_CARDS-1] deck_t;
  localparam deal_t DECK_INIT = 18'h0056A;
  typedef enum logic [2:0] {IDLE, INIT, PICK, SWAP, DONE} state_t;
endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1.
// Ports: clk, reset (sync, active-high, loads seed), seed[15:0], q[15:0].
// A zero seed is replaced by 1 so the register never locks up at 0.
module lfsr16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);
  logic [15:0] q_d;
  always_comb q_d = {q[0] ^ q[2] ^ q[3] ^ q[5], q[15:1]};
  always_ff @(posedge clk) q <= reset ? ((seed == '0) ? 16'h0001 : seed) : q_d;
endmodule

// File: rtl/deal_shuffler.sv
// deal_shuffler: bounded Fisher-Yates shuffle of a 9-card, 3-symbol deck.
// Ports: clk, reset (sync, active-high), start (level; rising edge requests
// a deal), deal[17:0] (card1 = [17:16]), valid, done (1-cycle pulse), busy.
// Macro DEAL_FIXED_EN: skip the shuffle and emit FIXED_DEAL (bring-up).
module deal_shuffler
  import card_pkg::*;
#(
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          MAX_REJECT = 8,
  parameter deal_t       FIXED_DEAL = 18'h0245A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [17:0] deal,
  output logic        valid,
  output logic        done,
  output logic        busy
);
`ifdef DEAL_FIXED_EN
  localparam bit FIXED_EN = 1'b1;
`else
  localparam bit FIXED_EN = 1'b0;
`endif
  localparam int RW = $clog2(MAX_REJECT + 1);
  localparam logic [RW-1:0] REJ_LAST = RW'(MAX_REJECT - 1);
  logic [15:0] lfsr_q;
  logic [3:0] r;
  logic start_q, rise;
  state_t state_q, state_d;
  deck_t work_q, work_d;
  logic [3:0] i_q, i_d, j_q, j_d;
  logic [RW-1:0] rej_q, rej_d;
  deal_t deal_q, deal_d;
  logic valid_q, valid_d, done_q, done_d, busy_q, busy_d;
  lfsr16 u_lfsr (.clk(clk), .reset(reset), .seed(SEED), .q(lfsr_q));
  assign r = lfsr_q[3:0];
  assign rise = start & ~start_q;
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    i_d     = i_q;
    j_d     = j_q;
    rej_d   = rej_q;
    deal_d  = deal_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: if (rise) begin
        state_d = INIT;
        valid_d = 1'b0;
        busy_d  = 1'b1;
      end
      INIT: begin
        work_d  = FIXED_EN ? FIXED_DEAL : DECK_INIT;
        i_d     = 4'd8;
        rej_d   = '0;
        busy_d  = 1'b1;
        state_d = FIXED_EN ? DONE : PICK;
      end
      // Out-of-range draws are rejected; after MAX_REJECT tries the card stays put.
      PICK: begin
        j_d     = (r <= i_q) ? r : i_q;
        state_d = (r <= i_q || rej_q == REJ_LAST) ? SWAP : PICK;
        rej_d   = (r <= i_q || rej_q == REJ_LAST) ? rej_q : rej_q + 1'b1;
      end
      SWAP: begin
        work_d[i_q] = work_q[j_q];
        work_d[j_q] = work_q[i_q];
        rej_d   = '0;
        i_d     = i_q - 4'd1;
        state_d = (i_q == 4'd1) ? DONE : PICK;
      end
      DONE: begin
        deal_d  = work_q;
        valid_d = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      work_q  <= DECK_INIT;
      i_q     <= '0;
      j_q     <= '0;
      rej_q   <= '0;
      deal_q  <= DECK_INIT;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      work_q  <= work_d;
      i_q     <= i_d;
      j_q     <= j_d;
      rej_q   <= rej_d;
      deal_q  <= deal_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end
  assign deal  = deal_q;
  assign valid = valid_q;
  assign done  = done_q;
  assign busy  = busy_q;
endmodule
